// File: rtl/reg_file_reader.sv
// Streams count words from a register file starting at base_addr (wrapping),
// presenting each word on a registered valid/ready output stage.
//
// state | meaning
// IDLE  | waiting for start; ptr holds its last value
// RUN   | loading words from the read port whenever the output slot is free
// DRAIN | final word loaded; waiting for its handshake before signalling done
module reg_file_reader #(
    parameter int address_width = 3,
    parameter int data_width    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [address_width-1:0] base_addr,
    input  logic [address_width:0]   count,
    output logic [address_width-1:0] read_address,
    input  logic [data_width-1:0]    read_data,
    output logic [data_width-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [address_width:0] REM_ONE = {{address_width{1'b0}}, 1'b1};

    state_t                   state, state_nx;
    logic [address_width-1:0] ptr, ptr_nx;
    logic [address_width:0]   remaining, remaining_nx;
    logic [data_width-1:0]    m_data_nx;
    logic                     m_valid_nx, m_last_nx, done_nx;
    logic                     slot_free;

    // The output slot can take a new word if it is empty or being consumed now.
    assign slot_free    = !m_valid || m_ready;
    assign read_address = ptr;
    assign busy         = (state != IDLE);

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        remaining_nx = remaining;
        m_data_nx    = m_data;
        m_valid_nx   = m_valid;
        m_last_nx    = m_last;
        done_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        ptr_nx       = base_addr;
                        remaining_nx = count;
                        state_nx     = RUN;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                if (slot_free) begin
                    m_data_nx    = read_data;
                    m_valid_nx   = 1'b1;
                    m_last_nx    = (remaining == REM_ONE);
                    ptr_nx       = ptr + 1'b1;
                    remaining_nx = remaining - 1'b1;
                    if (remaining == REM_ONE) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (m_valid && m_ready) begin
                    m_valid_nx = 1'b0;
                    m_last_nx  = 1'b0;
                    done_nx    = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            remaining <= remaining_nx;
            m_data    <= m_data_nx;
            m_valid   <= m_valid_nx;
            m_last    <= m_last_nx;
            done      <= done_nx;
        end
    end

endmodule
